// File: rtl/turret_pkg.sv
// Shared types and constants for the turret fire controller.
package turret_pkg;

  typedef enum logic [1:0] {ST_READY, ST_FLIGHT, ST_COOLDOWN} turret_state_t;

  localparam int unsigned AGE_W   = 8;
  localparam int unsigned CNT_MAX = 255;

endpackage

// File: rtl/turret_angle_reg.sv
// Saturating up/down aim-angle register; simultaneous inc and dec cancel out.
module turret_angle_reg
  import turret_pkg::*;
#(
  parameter int unsigned ANGLE_STEPS = 16,
  parameter int unsigned ANGLE_INIT  = 8,
  parameter int unsigned ANGLE_W     = $clog2(ANGLE_STEPS)
) (
  input  logic               fclk,
  input  logic               reset,
  input  logic               dec,
  input  logic               inc,
  output logic [ANGLE_W-1:0] value
);

  logic [ANGLE_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (dec && !inc && value_q != '0) begin
      value_d = value_q - 1'b1;
    end else if (inc && !dec && value_q != ANGLE_W'(ANGLE_STEPS - 1)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      value_q <= ANGLE_W'(ANGLE_INIT);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/turret_fire_ctrl.sv
// Turret state for the renderer: aim angle plus a READY -> FLIGHT -> COOLDOWN shot FSM.
module turret_fire_ctrl
  import turret_pkg::*;
#(
  parameter int unsigned ANGLE_STEPS     = 16,
  parameter int unsigned ANGLE_INIT      = 8,
  parameter int unsigned SHOT_FRAMES     = 60,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned ANGLE_W         = $clog2(ANGLE_STEPS)
) (
  input  logic               fclk,
  input  logic               reset,
  input  logic               left_pulse,
  input  logic               right_pulse,
  input  logic               fire_pulse,
  input  logic               hit,
  output logic [ANGLE_W-1:0] angle_idx,
  output logic [ANGLE_W-1:0] shot_angle,
  output logic               shot_active,
  output logic [AGE_W-1:0]   shot_age,
  output logic               fire_strobe,
  output logic               ready,
  output logic [AGE_W-1:0]   hit_count
);

  turret_state_t      state_q, state_d;
  logic [ANGLE_W-1:0] shot_angle_q, shot_angle_d;
  logic [AGE_W-1:0]   shot_age_q, shot_age_d;
  logic               fire_strobe_q, fire_strobe_d;
  logic [AGE_W-1:0]   hit_count_q, hit_count_d;
  logic [AGE_W-1:0]   cd_cnt_q, cd_cnt_d;

  turret_angle_reg #(
    .ANGLE_STEPS (ANGLE_STEPS),
    .ANGLE_INIT  (ANGLE_INIT),
    .ANGLE_W     (ANGLE_W)
  ) u_angle (
    .fclk  (fclk),
    .reset (reset),
    .dec   (left_pulse),
    .inc   (right_pulse),
    .value (angle_idx)
  );

  always_comb begin
    state_d       = state_q;
    shot_angle_d  = shot_angle_q;
    shot_age_d    = shot_age_q;
    fire_strobe_d = 1'b0;
    hit_count_d   = hit_count_q;
    cd_cnt_d      = cd_cnt_q;
    unique case (state_q)
      ST_READY: begin
        if (fire_pulse) begin
          state_d       = ST_FLIGHT;
          shot_age_d    = '0;
          fire_strobe_d = 1'b1;
          // angle_idx is still the pre-edge value here, so a same-tick aim step is excluded
          shot_angle_d  = angle_idx;
        end
      end
      ST_FLIGHT: begin
        if (hit) begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = '0;
          if (hit_count_q != AGE_W'(CNT_MAX)) begin
            hit_count_d = hit_count_q + 1'b1;
          end
        end else if (shot_age_q == AGE_W'(SHOT_FRAMES - 1)) begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = '0;
        end else begin
          shot_age_d = shot_age_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == AGE_W'(COOLDOWN_FRAMES - 1)) begin
          state_d = ST_READY;
        end else begin
          cd_cnt_d = cd_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_READY;
      shot_angle_q  <= '0;
      shot_age_q    <= '0;
      fire_strobe_q <= 1'b0;
      hit_count_q   <= '0;
      cd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      shot_angle_q  <= shot_angle_d;
      shot_age_q    <= shot_age_d;
      fire_strobe_q <= fire_strobe_d;
      hit_count_q   <= hit_count_d;
      cd_cnt_q      <= cd_cnt_d;
    end
  end

  assign shot_angle  = shot_angle_q;
  assign shot_age    = shot_age_q;
  assign fire_strobe = fire_strobe_q;
  assign hit_count   = hit_count_q;
  assign shot_active = (state_q == ST_FLIGHT);
  assign ready       = (state_q == ST_READY);

endmodule

// File: tb/tb_turret_fire_ctrl.sv
// Scoreboard bench for turret_fire_ctrl: stimulus pushes model expectations, a monitor checks each edge.
module tb_turret_fire_ctrl;

  localparam int STEPS = 16;
  localparam int INIT  = 8;
  localparam int SHOT  = 60;
  localparam int CD    = 30;

  logic       fclk = 1'b0;
  logic       reset = 1'b1;
  logic       left_pulse = 1'b0, right_pulse = 1'b0, fire_pulse = 1'b0, hit = 1'b0;
  logic [3:0] angle_idx, shot_angle;
  logic       shot_active, fire_strobe, ready;
  logic [7:0] shot_age, hit_count;

  always #5 fclk = ~fclk;

  turret_fire_ctrl dut (
    .fclk        (fclk),
    .reset       (reset),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .fire_pulse  (fire_pulse),
    .hit         (hit),
    .angle_idx   (angle_idx),
    .shot_angle  (shot_angle),
    .shot_active (shot_active),
    .shot_age    (shot_age),
    .fire_strobe (fire_strobe),
    .ready       (ready),
    .hit_count   (hit_count)
  );

  typedef struct {
    int angle;
    int sangle;
    int active;
    int age;
    int strobe;
    int rdy;
    int hits;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: mode 0 = waiting to fire, 1 = shot in the air, 2 = reloading.
  int m_mode, m_angle, m_sangle, m_age, m_hits, m_reload_left, m_strobe;

  function automatic void model_reset();
    m_mode = 0; m_angle = INIT; m_sangle = 0; m_age = 0; m_hits = 0;
    m_reload_left = 0; m_strobe = 0;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.angle  = m_angle;
    e.sangle = m_sangle;
    e.active = (m_mode == 1) ? 1 : 0;
    e.age    = m_age;
    e.strobe = m_strobe;
    e.rdy    = (m_mode == 0) ? 1 : 0;
    e.hits   = m_hits;
    return e;
  endfunction

  function automatic void model_edge(bit l, bit r, bit f, bit h);
    int prev_angle = m_angle;
    if (l && !r) m_angle = (m_angle > 0) ? m_angle - 1 : 0;
    if (r && !l) m_angle = (m_angle < STEPS - 1) ? m_angle + 1 : STEPS - 1;
    m_strobe = 0;
    case (m_mode)
      0: if (f) begin
        m_mode = 1; m_sangle = prev_angle; m_age = 0; m_strobe = 1;
      end
      1: begin
        if (h) begin
          m_hits = (m_hits < 255) ? m_hits + 1 : 255;
          m_mode = 2; m_reload_left = CD;
        end else if (m_age + 1 >= SHOT) begin
          m_mode = 2; m_reload_left = CD;
        end else begin
          m_age = m_age + 1;
        end
      end
      default: begin
        m_reload_left = m_reload_left - 1;
        if (m_reload_left == 0) m_mode = 0;
      end
    endcase
  endfunction

  task automatic check(input string tag, input exp_t e);
    n_vec++;
    if (angle_idx !== 4'(e.angle) || shot_angle !== 4'(e.sangle) ||
        shot_active !== 1'(e.active) || shot_age !== 8'(e.age) ||
        fire_strobe !== 1'(e.strobe) || ready !== 1'(e.rdy) || hit_count !== 8'(e.hits)) begin
      n_err++;
      $display("FAIL %s @%0t: got angle=%0d sangle=%0d active=%0d age=%0d strobe=%0d ready=%0d hits=%0d, want angle=%0d sangle=%0d active=%0d age=%0d strobe=%0d ready=%0d hits=%0d",
               tag, $time, angle_idx, shot_angle, shot_active, shot_age, fire_strobe, ready,
               hit_count, e.angle, e.sangle, e.active, e.age, e.strobe, e.rdy, e.hits);
    end
  endtask

  // One tick of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(input bit rst, input bit l, input bit r, input bit f, input bit h);
    @(negedge fclk);
    reset = rst; left_pulse = l; right_pulse = r; fire_pulse = f; hit = h;
    if (rst) model_reset();
    else model_edge(l, r, f, h);
    sb.push_back(model_snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge fclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("edge", e);
      end
    end
  end

  initial begin : stimulus
    int k;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(SHOT + CD + 5);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, i % 3 == 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < CD; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge fclk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", model_snapshot());
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(SHOT + CD + 2);

    for (int n = 0; n < 260; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      k = $urandom_range(0, SHOT - 2);
      for (int i = 0; i < k; i++) step(1'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                                       1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      k = $urandom_range(0, CD - 1);
      for (int i = 0; i < CD; i++) step(1'b0, 1'b0, 1'b0, 1'b0, i == k);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge fclk);
    #2;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
